ahb_arbiter: RTL and testbench

AHB_ARBITER -- requirements
Module: ahb_arbiter

---
 rtl/ahb_arb_pkg.sv | 37 +++
 rtl/ahb_rr_picker.sv | 24 ++
 rtl/ahb_arbiter.sv | 134 +++++++++++++
 tb/tb_ahb_arbiter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_arb_pkg.sv
// Shared AHB arbiter types: FSM states, htrans/hburst codes and
// the helper that maps a burst type to its remaining-beat count.
package ahb_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_GRANTED,
      ST_BURST,
      ST_LOCKED
   } arb_state_e;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HBURST_SINGLE = 3'd0;
   localparam logic [2:0] HBURST_INCR   = 3'd1;
   localparam logic [2:0] HBURST_WRAP4  = 3'd2;
   localparam logic [2:0] HBURST_INCR4  = 3'd3;
   localparam logic [2:0] HBURST_WRAP8  = 3'd4;
   localparam logic [2:0] HBURST_INCR8  = 3'd5;
   localparam logic [2:0] HBURST_WRAP16 = 3'd6;
   localparam logic [2:0] HBURST_INCR16 = 3'd7;

   // SEQ beats still to come after the NONSEQ; 0 means not a burst
   function automatic logic [3:0] burst_beats(input logic [2:0] hburst);
      case (hburst)
         HBURST_SINGLE, HBURST_INCR:   return 4'd0;
         HBURST_WRAP4,  HBURST_INCR4:  return 4'd3;
         HBURST_WRAP8,  HBURST_INCR8:  return 4'd7;
         HBURST_WRAP16, HBURST_INCR16: return 4'd15;
         default:                      return 4'd0;
      endcase
   endfunction

endpackage

// File: rtl/ahb_rr_picker.sv
// Round-robin picker: one-hot winner among req, searching from ptr
// upward and wrapping to 0. Ports: req, ptr in; gnt (0 if no req) out.
module ahb_rr_picker #(
   parameter int NUM_MGR   = 4,
   parameter int PTR_WIDTH = 2
) (
   input  logic [NUM_MGR-1:0]   req,
   input  logic [PTR_WIDTH-1:0] ptr,
   output logic [NUM_MGR-1:0]   gnt
);

   logic [NUM_MGR-1:0] mask;
   logic [NUM_MGR-1:0] hi;
   logic [NUM_MGR-1:0] sel;

   // requests at or above ptr win first; otherwise wrap to the bottom
   always_comb begin
      mask = ~((NUM_MGR'(1) << ptr) - NUM_MGR'(1));
      hi   = req & mask;
      sel  = (|hi) ? hi : req;
      gnt  = sel & (~sel + NUM_MGR'(1));
   end

endmodule

// File: rtl/ahb_arbiter.sv
// AHB bus arbiter: round-robin grant with burst and locked-sequence hold.
// In: hclk, hreset, hbusreq, hlock, htrans, hburst, hready.
// Out: hgrant (one-hot), hmaster, hmaster_data, hmastlock.
module ahb_arbiter
   import ahb_arb_pkg::*;
#(
   parameter int NUM_MGR       = 4,
   parameter int HMASTER_WIDTH = 2,
   parameter int DEFAULT_MGR   = 0
) (
   input  logic                     hclk,
   input  logic                     hreset,
   input  logic [NUM_MGR-1:0]       hbusreq,
   input  logic [NUM_MGR-1:0]       hlock,
   input  logic [1:0]               htrans,
   input  logic [2:0]               hburst,
   input  logic                     hready,
   output logic [NUM_MGR-1:0]       hgrant,
   output logic [HMASTER_WIDTH-1:0] hmaster,
   output logic [HMASTER_WIDTH-1:0] hmaster_data,
   output logic                     hmastlock
);

   arb_state_e               state_q, state_d;
   logic [3:0]               cnt_q, cnt_d;
   logic [NUM_MGR-1:0]       grant_q, grant_d;
   logic [HMASTER_WIDTH-1:0] last_q, last_d;
   logic [HMASTER_WIDTH-1:0] ptr;
   logic [HMASTER_WIDTH-1:0] win_idx;
   logic [NUM_MGR-1:0]       win;
   logic [3:0]               beats;
   logic                     arb;
   logic                     own_lock;
   logic                     own_hlock;

   assign ptr = (last_q == HMASTER_WIDTH'(NUM_MGR - 1))
              ? '0 : last_q + HMASTER_WIDTH'(1);

   ahb_rr_picker #(
      .NUM_MGR   (NUM_MGR),
      .PTR_WIDTH (HMASTER_WIDTH)
   ) u_picker (
      .req (hbusreq),
      .ptr (ptr),
      .gnt (win)
   );

   always_comb begin
      hmaster = '0;
      win_idx = '0;
      for (int i = 0; i < NUM_MGR; i++) begin
         if (grant_q[i]) hmaster = HMASTER_WIDTH'(i);
         if (win[i])     win_idx = HMASTER_WIDTH'(i);
      end
   end

   assign hgrant    = grant_q;
   // grant cannot move while locked, so the owner is the locker
   assign hmastlock = (state_q == ST_LOCKED);
   assign own_hlock = |(hlock & grant_q);
   assign own_lock  = |(hlock & hbusreq & grant_q);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      grant_d = grant_q;
      last_d  = last_q;
      arb     = 1'b0;
      beats   = burst_beats(hburst);
      if (hready) begin
         unique case (state_q)
            ST_IDLE, ST_GRANTED: begin
               // lock and burst start keep the owner; else rearbitrate
               if (own_lock) begin
                  state_d = ST_LOCKED;
               end else if (htrans == HTRANS_NONSEQ && beats != 4'd0) begin
                  state_d = ST_BURST;
                  cnt_d   = beats;
               end else begin
                  arb = 1'b1;
               end
            end
            ST_BURST: begin
               unique case (htrans)
                  HTRANS_IDLE, HTRANS_NONSEQ: begin
                     cnt_d = '0;
                     arb   = 1'b1;
                  end
                  HTRANS_SEQ: begin
                     if (cnt_q <= 4'd1) begin
                        cnt_d = '0;
                        arb   = 1'b1;
                     end else begin
                        cnt_d = cnt_q - 4'd1;
                     end
                  end
                  HTRANS_BUSY: ;
                  default: ;
               endcase
            end
            ST_LOCKED: begin
               if (!own_hlock && htrans == HTRANS_IDLE) arb = 1'b1;
            end
            default: ;
         endcase
      end
      if (arb) begin
         if (|hbusreq) begin
            grant_d = win;
            last_d  = win_idx;
            state_d = ST_GRANTED;
         end else begin
            state_d = ST_IDLE;
         end
      end
   end

   always_ff @(posedge hclk or posedge hreset) begin
      if (hreset) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         grant_q      <= NUM_MGR'(1) << DEFAULT_MGR;
         last_q       <= HMASTER_WIDTH'(DEFAULT_MGR);
         hmaster_data <= HMASTER_WIDTH'(DEFAULT_MGR);
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         if (hready) hmaster_data <= hmaster;
      end
   end

endmodule

// File: tb/tb_ahb_arbiter.sv
// Self-checking bench for ahb_arbiter: directed scenarios plus random
// traffic, all compared against a transaction-level reference model.
module tb_ahb_arbiter;

   logic       hclk;
   logic       hreset;
   logic [3:0] hbusreq;
   logic [3:0] hlock;
   logic [1:0] htrans;
   logic [2:0] hburst;
   logic       hready;
   logic [3:0] hgrant;
   logic [1:0] hmaster;
   logic [1:0] hmaster_data;
   logic       hmastlock;

   ahb_arbiter #(
      .NUM_MGR       (4),
      .HMASTER_WIDTH (2),
      .DEFAULT_MGR   (0)
   ) dut (
      .hclk         (hclk),
      .hreset       (hreset),
      .hbusreq      (hbusreq),
      .hlock        (hlock),
      .htrans       (htrans),
      .hburst       (hburst),
      .hready       (hready),
      .hgrant       (hgrant),
      .hmaster      (hmaster),
      .hmaster_data (hmaster_data),
      .hmastlock    (hmastlock)
   );

   initial hclk = 1'b0;
   always #5 hclk = ~hclk;

   int n_err;
   int n_chk;

   logic [1:0] m_own;
   logic [1:0] m_last;
   logic [1:0] m_data;
   bit         m_lock;
   int         m_left;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_own  = 2'd0;
      m_last = 2'd0;
      m_data = 2'd0;
      m_lock = 1'b0;
      m_left = 0;
   endtask

   task automatic model_step();
      bit         ho;
      bit         found;
      logic [1:0] idx;
      logic [1:0] pick;
      if (!hready) return;
      m_data = m_own;
      ho     = 1'b0;
      if (m_lock) begin
         if (!hlock[m_own] && htrans == 2'd0) begin
            ho     = 1'b1;
            m_lock = 1'b0;
         end
      end else if (m_left > 0) begin
         if (htrans == 2'd0 || htrans == 2'd2) begin
            m_left = 0;
            ho     = 1'b1;
         end else if (htrans == 2'd3) begin
            m_left--;
            if (m_left == 0) ho = 1'b1;
         end
      end else if (hlock[m_own] && hbusreq[m_own]) begin
         m_lock = 1'b1;
      end else if (htrans == 2'd2 && hburst >= 3'd2) begin
         m_left = (4 << ((int'(hburst) - 2) >> 1)) - 1;
      end else begin
         ho = 1'b1;
      end
      if (ho) begin
         found = 1'b0;
         pick  = m_own;
         for (int k = 1; k <= 4; k++) begin
            idx = m_last + 2'(k);
            if (!found && hbusreq[idx]) begin
               found = 1'b1;
               pick  = idx;
            end
         end
         if (found) begin
            m_own  = pick;
            m_last = pick;
         end
      end
   endtask

   task automatic cmp_all();
      chk("hgrant", 32'(hgrant), 32'(4'b0001 << m_own));
      chk("hmaster", 32'(hmaster), 32'(m_own));
      chk("hmaster_data", 32'(hmaster_data), 32'(m_data));
      chk("hmastlock", 32'(hmastlock), 32'(m_lock));
      chk("onehot", 32'($onehot(hgrant)), 32'd1);
   endtask

   task automatic cyc(input logic [3:0] rq, input logic [3:0] lk,
                      input logic [1:0] tr, input logic [2:0] bu,
                      input logic rd);
      hbusreq = rq;
      hlock   = lk;
      htrans  = tr;
      hburst  = bu;
      hready  = rd;
      @(posedge hclk);
      model_step();
      #1;
      cmp_all();
   endtask

   initial begin
      n_err   = 0;
      n_chk   = 0;
      hreset  = 1'b1;
      hbusreq = '0;
      hlock   = '0;
      htrans  = 2'd0;
      hburst  = 3'd0;
      hready  = 1'b1;
      model_reset();
      repeat (2) @(posedge hclk);
      #1;
      cmp_all();
      hreset = 1'b0;

      // all request, single transfers: rotate 1,2,3,0
      for (int k = 1; k <= 4; k++) begin
         cyc(4'b1111, 4'b0, 2'd2, 3'd0, 1'b1);
         chk("rotate", 32'(hmaster), 32'(k % 4));
      end

      // mgr1 INCR8 while mgr2 requests
      cyc(4'b0010, 4'b0, 2'd0, 3'd0, 1'b1);
      cyc(4'b0110, 4'b0, 2'd2, 3'd5, 1'b1);
      for (int i = 1; i <= 7; i++) begin
         cyc(4'b0110, 4'b0, 2'd3, 3'd5, 1'b1);
         chk("incr8", 32'(hmaster), (i < 7) ? 32'd1 : 32'd2);
      end

      // WRAP4 from mgr2 with BUSY and wait states
      cyc(4'b0101, 4'b0, 2'd2, 3'd2, 1'b1);
      cyc(4'b0101, 4'b0, 2'd3, 3'd2, 1'b1);
      chk("wrap4_b2", 32'(hmaster), 32'd2);
      cyc(4'b0101, 4'b0, 2'd1, 3'd2, 1'b1);
      cyc(4'b0101, 4'b0, 2'd3, 3'd2, 1'b0);
      chk("wrap4_wait", 32'(hmaster), 32'd2);
      cyc(4'b0101, 4'b0, 2'd3, 3'd2, 1'b1);
      cyc(4'b0101, 4'b0, 2'd1, 3'd2, 1'b1);
      chk("wrap4_b3", 32'(hmaster), 32'd2);
      cyc(4'b0101, 4'b0, 2'd3, 3'd2, 1'b1);
      chk("wrap4_end", 32'(hmaster), 32'd0);

      // mgr3 locked sequence with mgr0 requesting
      cyc(4'b1000, 4'b0, 2'd0, 3'd0, 1'b1);
      cyc(4'b1001, 4'b1000, 2'd2, 3'd0, 1'b1);
      chk("lock_on", 32'(hmastlock), 32'd1);
      cyc(4'b1001, 4'b1000, 2'd0, 3'd0, 1'b1);
      chk("lock_hold", 32'(hmaster), 32'd3);
      cyc(4'b1001, 4'b0000, 2'd2, 3'd0, 1'b1);
      chk("lock_nsq", 32'(hmaster), 32'd3);
      cyc(4'b1001, 4'b0000, 2'd0, 3'd0, 1'b0);
      chk("lock_wait", 32'(hmastlock), 32'd1);
      cyc(4'b1001, 4'b0000, 2'd0, 3'd0, 1'b1);
      chk("lock_rel", 32'(hmaster), 32'd0);
      chk("lock_off", 32'(hmastlock), 32'd0);

      // INCR4 cut short by NONSEQ after beat 2
      cyc(4'b0011, 4'b0, 2'd2, 3'd3, 1'b1);
      cyc(4'b0011, 4'b0, 2'd3, 3'd3, 1'b1);
      chk("early_b2", 32'(hmaster), 32'd0);
      cyc(4'b0011, 4'b0, 2'd2, 3'd3, 1'b1);
      chk("early_end", 32'(hmaster), 32'd1);

      // reset in the middle of an INCR16
      cyc(4'b0010, 4'b0, 2'd2, 3'd7, 1'b1);
      repeat (3) cyc(4'b0010, 4'b0, 2'd3, 3'd7, 1'b1);
      hreset = 1'b1;
      #1;
      chk("rst_grant", 32'(hgrant), 32'h1);
      chk("rst_master", 32'(hmaster), 32'h0);
      chk("rst_lock", 32'(hmastlock), 32'h0);
      model_reset();
      @(posedge hclk);
      #1;
      hreset = 1'b0;
      cmp_all();
      cyc(4'b0100, 4'b0, 2'd3, 3'd7, 1'b1);
      chk("post_rst", 32'(hmaster), 32'd2);

      // random traffic
      for (int n = 0; n < 3000; n++) begin
         logic [3:0] rq;
         logic [3:0] lk;
         logic [1:0] tr;
         logic [2:0] bu;
         logic       rd;
         rq = 4'($urandom);
         if ($urandom % 6 == 0) rq = '0;
         lk = '0;
         if ($urandom % 10 == 0) lk = 4'($urandom);
         if (m_lock && $urandom % 4 != 0) lk[m_own] = 1'b1;
         if (m_left > 0) begin
            case ($urandom % 12)
               0:       tr = 2'd0;
               1:       tr = 2'd2;
               2, 3:    tr = 2'd1;
               default: tr = 2'd3;
            endcase
         end else begin
            tr = 2'($urandom);
         end
         bu = 3'($urandom);
         rd = ($urandom % 5 != 0);
         cyc(rq, lk, tr, bu, rd);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
